// File: rtl/spi_pkg.sv
// Shared constants for the duplex SPI master: FSM state encoding and
// the bit layout of the {CPOL, CPHA} mode field.
package spi_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SETUP = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  localparam int MODE_CPOL_BIT = 1;
  localparam int MODE_CPHA_BIT = 0;

  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

endpackage

// File: rtl/spi_clock_gen.sv
// SCK timebase: a DIVIDER-cycle tick down-counter and a down-counter over the
// 2*WIDTH SCK toggles, decoded into leading/trailing/last-toggle strobes.
module spi_clock_gen #(
  parameter int WIDTH   = 16,
  parameter int DIVIDER = 2
) (
  input  logic clock,
  input  logic resetN,
  input  logic i_start,
  input  logic i_run,
  input  logic i_shift,
  output logic o_tick,
  output logic o_lead,
  output logic o_trail,
  output logic o_last
);

  localparam int TW = $clog2(DIVIDER + 1);
  localparam int EW = $clog2(2 * WIDTH);
  localparam logic [TW-1:0] TICK_LOAD = TW'(DIVIDER - 1);
  localparam logic [EW-1:0] EDGE_LOAD = EW'(2 * WIDTH - 1);

  logic [TW-1:0] r_tick_cnt;
  logic [EW-1:0] r_edge_cnt;
  logic          w_edge;

  assign o_tick = i_run && (r_tick_cnt == '0);
  assign w_edge = o_tick && i_shift;

  // Toggles remaining counts down from 2*WIDTH-1, so an odd count marks a leading edge.
  assign o_lead  = w_edge && r_edge_cnt[0];
  assign o_trail = w_edge && !r_edge_cnt[0];
  assign o_last  = w_edge && (r_edge_cnt == '0);

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_tick_cnt <= '0;
      r_edge_cnt <= '0;
    end else begin
      if (i_start) begin
        r_tick_cnt <= TICK_LOAD;
        r_edge_cnt <= EDGE_LOAD;
      end else begin
        if (i_run) begin
          r_tick_cnt <= o_tick ? TICK_LOAD : (r_tick_cnt - TW'(1));
        end
        if (w_edge && (r_edge_cnt != '0)) begin
          r_edge_cnt <= r_edge_cnt - EW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/spi_master_duplex.sv
// Full-duplex SPI master, MSB first, all four CPOL/CPHA modes, busy/done handshake.
// state | meaning: IDLE wait for writeSPI | SETUP CS low, SCK idle | SHIFT 2*WIDTH toggles | HOLD CS hold before done
module spi_master_duplex
  import spi_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int DIVIDER = 2
) (
  input  logic             clock,
  input  logic             resetN,
  input  logic [WIDTH-1:0] data,
  input  logic             writeSPI,
  input  logic [1:0]       mode,
  input  logic             MISO,
  output logic [WIDTH-1:0] readData,
  output logic             done,
  output logic             busy,
  output logic             masterChipSelectN,
  output logic             SCK,
  output logic             MOSI
);

  logic [1:0]       r_state;
  logic [1:0]       r_mode;
  logic [WIDTH-1:0] r_tx_sr;
  logic [WIDTH-1:0] r_rx_sr;
  logic [WIDTH-1:0] r_read_data;
  logic             r_mosi;
  logic             r_sck;
  logic             r_csn;
  logic             r_busy;
  logic             r_done;

  logic w_start;
  logic w_in_shift;
  logic w_tick;
  logic w_lead;
  logic w_trail;
  logic w_last;
  logic w_cpha;
  logic w_tx_shift;
  logic w_rx_sample;

  assign w_start    = (r_state == ST_IDLE) && writeSPI;
  assign w_in_shift = (r_state == ST_SHIFT);
  assign w_cpha     = r_mode[MODE_CPHA_BIT];

  // CPHA=0 never shifts on the final trailing edge so MOSI keeps bit 0 through HOLD.
  assign w_tx_shift  = w_cpha ? w_lead : (w_trail && !w_last);
  assign w_rx_sample = w_cpha ? w_trail : w_lead;

  spi_clock_gen #(
    .WIDTH   (WIDTH),
    .DIVIDER (DIVIDER)
  ) u_clock_gen (
    .clock   (clock),
    .resetN  (resetN),
    .i_start (w_start),
    .i_run   (r_busy),
    .i_shift (w_in_shift),
    .o_tick  (w_tick),
    .o_lead  (w_lead),
    .o_trail (w_trail),
    .o_last  (w_last)
  );

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_state     <= ST_IDLE;
      r_mode      <= 2'b00;
      r_tx_sr     <= '0;
      r_rx_sr     <= '0;
      r_read_data <= '0;
      r_mosi      <= 1'b0;
      r_sck       <= 1'b0;
      r_csn       <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_mode <= mode;
          r_sck  <= mode[MODE_CPOL_BIT];
          if (writeSPI) begin
            r_state <= ST_SETUP;
            r_csn   <= 1'b0;
            r_busy  <= 1'b1;
            r_mosi  <= data[WIDTH-1];
            r_rx_sr <= '0;
            // CPHA=1 re-drives the MSB on the first leading edge, so it keeps the full word.
            r_tx_sr <= mode[MODE_CPHA_BIT] ? data : {data[WIDTH-2:0], 1'b0};
          end
        end
        ST_SETUP: begin
          if (w_tick) begin
            r_state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (w_tick) begin
            r_sck <= ~r_sck;
            if (w_tx_shift) begin
              r_mosi  <= r_tx_sr[WIDTH-1];
              r_tx_sr <= {r_tx_sr[WIDTH-2:0], 1'b0};
            end
            if (w_rx_sample) begin
              r_rx_sr <= {r_rx_sr[WIDTH-2:0], MISO};
            end
            if (w_last) begin
              r_state <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (w_tick) begin
            r_state     <= ST_IDLE;
            r_csn       <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
            r_read_data <= r_rx_sr;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign readData          = r_read_data;
  assign done              = r_done;
  assign busy              = r_busy;
  assign masterChipSelectN = r_csn;
  assign SCK               = r_sck;
  assign MOSI              = r_mosi;

endmodule

// File: tb/tb_spi_master_duplex.sv
// Scoreboard bench for spi_master_duplex: a 16-bit/DIVIDER=2 instance with a
// protocol-level slave, and an 8-bit/DIVIDER=1 instance in loopback.
module tb_spi_master_duplex;
  import spi_pkg::*;

  localparam int WA = 16;
  localparam int DA = 2;
  localparam int WB = 8;
  localparam int DB = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n_a, ws_a, miso_a, done_a, busy_a, csn_a, sck_a, mosi_a;
  logic [WA-1:0] data_a, rd_a;
  logic [1:0]    mode_a;
  logic          rst_n_b, ws_b, miso_b, done_b, busy_b, csn_b, sck_b, mosi_b;
  logic [WB-1:0] data_b, rd_b;
  logic [1:0]    mode_b;

  logic          loopback   = 1'b1;
  logic          slave_miso = 1'b0;
  logic [WA-1:0] slave_word = '0;
  logic [1:0]    cur_mode   = 2'b00;

  assign miso_a = loopback ? mosi_a : slave_miso;
  assign miso_b = mosi_b;

  spi_master_duplex #(.WIDTH(WA), .DIVIDER(DA)) u_dut_a (
    .clock(clk), .resetN(rst_n_a), .data(data_a), .writeSPI(ws_a), .mode(mode_a),
    .MISO(miso_a), .readData(rd_a), .done(done_a), .busy(busy_a),
    .masterChipSelectN(csn_a), .SCK(sck_a), .MOSI(mosi_a));

  spi_master_duplex #(.WIDTH(WB), .DIVIDER(DB)) u_dut_b (
    .clock(clk), .resetN(rst_n_b), .data(data_b), .writeSPI(ws_b), .mode(mode_b),
    .MISO(miso_b), .readData(rd_b), .done(done_b), .busy(busy_b),
    .masterChipSelectN(csn_b), .SCK(sck_b), .MOSI(mosi_b));

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [WA-1:0] rx;
    logic [WA-1:0] tx;
    logic [1:0]    mode;
  } exp_t;

  exp_t          exp_q[$];
  logic [WB-1:0] exp_qb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Slave: drives its word MSB first and captures MOSI on the sampling edges of cur_mode.
  logic          s_active = 1'b0, s_prev_sck = 1'b0, s_prev_mosi = 1'b0;
  logic [WA-1:0] s_tx = '0, s_rx = '0;
  int            s_stab = 0;

  always @(negedge clk) begin
    if (!rst_n_a || csn_a) begin
      s_active = 1'b0;
    end else if (!s_active) begin
      s_active = 1'b1;
      s_rx     = '0;
      s_stab   = 0;
      s_tx     = slave_word;
      if (!cur_mode[0]) begin
        slave_miso = s_tx[WA-1];
        s_tx       = {s_tx[WA-2:0], 1'b0};
      end
    end else if (sck_a != s_prev_sck) begin
      if ((sck_a != cur_mode[1]) != cur_mode[0]) begin
        s_rx = {s_rx[WA-2:0], mosi_a};
        if (mosi_a != s_prev_mosi) s_stab++;
      end else begin
        slave_miso = s_tx[WA-1];
        s_tx       = {s_tx[WA-2:0], 1'b0};
      end
    end
    s_prev_sck  = sck_a;
    s_prev_mosi = mosi_a;
  end

  // Monitor A: measures CS low/high time and SCK rises, checks each done against the queue.
  int   cs_len = 0, rises = 0, hi_len = 0, last_gap = 0;
  logic m_prev_csn = 1'b1, m_prev_sck = 1'b0;
  exp_t m_e;

  always @(negedge clk) begin
    if (!csn_a) begin
      if (m_prev_csn) begin
        cs_len   = 1;
        rises    = 0;
        last_gap = hi_len;
      end else begin
        cs_len++;
        if (sck_a && !m_prev_sck) rises++;
      end
    end else begin
      hi_len = m_prev_csn ? hi_len + 1 : 1;
    end
    if (done_a) begin
      chk("a_done_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        m_e = exp_q.pop_front();
        chk("a_readData", 32'(rd_a), 32'(m_e.rx));
        chk("a_mosi_word", 32'(s_rx), 32'(m_e.tx));
        chk("a_mosi_stable", s_stab, 0);
        chk("a_cs_low_len", cs_len, (2 * WA + 2) * DA);
        chk("a_sck_rises", rises, WA);
        chk("a_sck_idle", 32'(sck_a), 32'(m_e.mode[1]));
        chk("a_busy_at_done", 32'(busy_a), 0);
      end
    end
    m_prev_csn = csn_a;
    m_prev_sck = sck_a;
  end

  int   cs_len_b = 0;
  logic mb_prev_csn = 1'b1;

  always @(negedge clk) begin
    if (!csn_b) cs_len_b = mb_prev_csn ? 1 : cs_len_b + 1;
    if (done_b) begin
      chk("b_done_expected", 32'(exp_qb.size() != 0), 1);
      if (exp_qb.size() != 0) begin
        chk("b_readData", 32'(rd_b), 32'(exp_qb.pop_front()));
        chk("b_cs_low_len", cs_len_b, (2 * WB + 2) * DB);
      end
    end
    mb_prev_csn = csn_b;
  end

  task automatic start_a(input logic [WA-1:0] d, input logic [1:0] m, input logic lb,
                         input logic [WA-1:0] sw, input logic expect_it);
    @(negedge clk);
    data_a = d; mode_a = m; loopback = lb; slave_word = sw; cur_mode = m; ws_a = 1'b1;
    if (expect_it) exp_q.push_back('{rx: (lb ? d : sw), tx: d, mode: m});
    @(negedge clk);
    ws_a = 1'b0;
    chk("a_start_busy", 32'(busy_a), 1);
    chk("a_start_mosi_msb", 32'(mosi_a), 32'(d[WA-1]));
    data_a = WA'($urandom);
    mode_a = 2'($urandom);
  endtask

  task automatic wait_idle_a(input string name);
    int n = 0;
    @(negedge clk);
    while (busy_a && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(busy_a), 0);
  endtask

  task automatic xfer_b(input logic [WB-1:0] d, input logic [1:0] m);
    int n = 0;
    @(negedge clk);
    data_b = d; mode_b = m; ws_b = 1'b1;
    exp_qb.push_back(d);
    @(negedge clk);
    ws_b = 1'b0;
    data_b = WB'($urandom);
    while (busy_b && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("b_idle", 32'(busy_b), 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n_a = 1'b0; rst_n_b = 1'b0;
    ws_a = 1'b0; ws_b = 1'b0;
    data_a = '0; data_b = '0;
    mode_a = MODE2; mode_b = MODE0;
    repeat (3) @(negedge clk);
    chk("rst_csn", 32'(csn_a), 1);
    chk("rst_sck", 32'(sck_a), 0);
    chk("rst_mosi", 32'(mosi_a), 0);
    chk("rst_busy", 32'(busy_a), 0);
    chk("rst_done", 32'(done_a), 0);
    chk("rst_readData", 32'(rd_a), 0);
    mode_a = MODE0;
    rst_n_a = 1'b1; rst_n_b = 1'b1;
    repeat (2) @(negedge clk);

    start_a(16'h5055, MODE0, 1'b1, '0, 1'b1);
    wait_idle_a("mode0_loopback_idle");

    for (int m = 1; m < 4; m++) begin
      start_a(16'hD655, 2'(m), 1'b0, 16'hA5C3, 1'b1);
      wait_idle_a("slave_mode_idle");
    end

    for (int i = 0; i < 8; i++) begin
      start_a(WA'($urandom), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              WA'($urandom), 1'b1);
      wait_idle_a("random_idle");
    end

    // Back-to-back: second request lands in the done cycle.
    start_a(16'h1255, MODE0, 1'b1, '0, 1'b1);
    n = 0;
    while (!done_a && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_first_done", 32'(done_a), 1);
    data_a = 16'hFFFF; mode_a = MODE0; ws_a = 1'b1;
    exp_q.push_back('{rx: 16'hFFFF, tx: 16'hFFFF, mode: MODE0});
    @(negedge clk);
    ws_a = 1'b0;
    chk("b2b_restart_busy", 32'(busy_a), 1);
    wait_idle_a("b2b_idle");
    chk("b2b_cs_high_gap", last_gap, 1);

    // A request while busy must be dropped.
    start_a(16'h3C96, MODE1, 1'b1, '0, 1'b1);
    repeat (9) @(negedge clk);
    data_a = 16'h0F0F; ws_a = 1'b1;
    @(negedge clk);
    ws_a = 1'b0;
    wait_idle_a("ignore_idle");
    repeat (4) @(negedge clk);
    chk("ignore_not_restarted", 32'(busy_a), 0);

    // Reset mid-transfer aborts without done.
    start_a(16'hC3A5, MODE2, 1'b0, 16'h7E81, 1'b0);
    repeat (29) @(negedge clk);
    rst_n_a = 1'b0;
    #1;
    chk("abort_csn", 32'(csn_a), 1);
    chk("abort_sck", 32'(sck_a), 0);
    chk("abort_busy", 32'(busy_a), 0);
    chk("abort_readData", 32'(rd_a), 0);
    @(negedge clk);
    rst_n_a = 1'b1;
    mode_a = MODE0;
    repeat (200) @(negedge clk);
    chk("abort_stays_idle", 32'(busy_a), 0);
    chk("abort_readData_after", 32'(rd_a), 0);

    xfer_b(8'h81, MODE3);
    for (int i = 0; i < 6; i++) xfer_b(WB'($urandom), 2'($urandom_range(0, 3)));

    repeat (5) @(negedge clk);
    chk("a_queue_drained", exp_q.size(), 0);
    chk("b_queue_drained", exp_qb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_master_duplex.md
# spi_master_duplex

Parametrised full-duplex SPI master, the successor to the fixed 16-bit, transmit-only SPI output block. It adds:
- configurable word width and SCK rate;
- all four CPOL/CPHA modes;
- an explicit SCK output and MISO capture;
- a busy/done handshake.

It sits between the CPU's I/O register file and external SPI pins. A loopback of MOSI to MISO gives a self-test path.

## Interface
Parameters:
- WIDTH, 16: bits per transfer, MSB first; legal range 2..32.
- DIVIDER, 2: system clocks per SCK half-period; legal range ≥1.

Ports:
- clock  in  1  system clock; all logic on its rising edge.
- resetN  in  1  asynchronous, active-low reset.
- data  in  WIDTH  transmit word; sampled when a start is accepted.
- writeSPI  in  1  start request; accepted only in IDLE.
- mode  in  2  {CPOL, CPHA}; sampled when a start is accepted.
- MISO  in  1  serial input from the slave.
- readData  out  WIDTH  last received word; updated at end of transfer.
- done  out  1  one-cycle pulse at end of transfer.
- busy  out  1  high while a transfer is in progress.
- masterChipSelectN  out  1  active-low chip select.
- SCK  out  1  serial clock.
- MOSI  out  1  serial output.

## Operation
Reset values (while resetN=0, effective immediately):
- masterChipSelectN=1, SCK=0, MOSI=0, busy=0, done=0, readData=0, state=IDLE, mode register=0.
- Reset asserted mid-transfer aborts it; no done pulse and readData is not updated.

IDLE:
- Mode register reloads from mode every cycle; SCK = registered CPOL.
- writeSPI=1 at a rising edge latches data into the shifter and freezes the mode register.
- Next state SETUP; next cycle masterChipSelectN=0, busy=1, MOSI = data[WIDTH-1].

SETUP:
- Lasts DIVIDER cycles with SCK at CPOL, then go to SHIFT.

SHIFT:
- 2·WIDTH SCK toggles, one every DIVIDER cycles; the first toggle is a leading edge.
- CPHA=0: sample MISO on each leading edge; shift MOSI on each trailing edge except the last.
- CPHA=1: shift MOSI on each leading edge, including the first; sample MISO on each trailing edge.
- Received bits shift in at the LSB, so the first received bit ends at readData[WIDTH-1].
- After the 2·WIDTH-th toggle SCK is back at CPOL; go to HOLD.

HOLD:
- Lasts DIVIDER cycles; MOSI holds its last value.
- Then: masterChipSelectN=1, busy=0, done=1 for one cycle, readData loads the assembled word, state=IDLE.

Rules:
- writeSPI while busy=1 is ignored and not queued.
- writeSPI in the done cycle is accepted, since the block is already in IDLE.
- mode or data changes while busy have no effect on the transfer in progress.

## Timing
- Start accepted at edge 0; masterChipSelectN falls after edge 0.
- masterChipSelectN stays low for exactly DIVIDER·(2·WIDTH+2) cycles.
- done, busy deassertion, masterChipSelectN rise and the readData update all occur in the same cycle.
- Minimum masterChipSelectN high time between back-to-back transfers is 1 cycle.
- SCK half-period is exactly DIVIDER cycles. All outputs are registered; no combinational path from input to output.
- DIVIDER=1: SCK = clock/2; the sampling edge and the shift edge are in different cycles.

## Structure
- Shared package spi_pkg: state encoding (IDLE, SETUP, SHIFT, HOLD), CPOL/CPHA bit indices, mode constants MODE0..MODE3.
- One sub-module, spi_clock_gen:
  - DIVIDER-cycle tick counter, $clog2(DIVIDER+1) bits wide;
  - edge counter over 2·WIDTH toggles;
  - leading/trailing strobes.
- The FSM, shifters and output registers live in spi_master_duplex.

## Test plan
All scenarios use WIDTH=16, DIVIDER=2 unless stated otherwise.
- Mode 0 loopback (MOSI→MISO): data=16'h5055, pulse writeSPI → masterChipSelectN low for 68 cycles, 16 SCK rising edges, done pulse, readData=16'h5055.
- Modes 1/2/3 with a slave model returning 16'hA5C3: data=16'hD655 → readData=16'hA5C3; SCK idles at CPOL; MOSI is stable on every sampling edge.
- Back-to-back transfers: 16'h1255 then 16'hFFFF, second writeSPI in the done cycle → masterChipSelectN high for exactly 1 cycle; both readData values correct.
- writeSPI pulsed 10 cycles into a transfer → ignored; one done pulse only, transfer length unchanged.
- resetN low at cycle 30 of a transfer → immediately masterChipSelectN=1, SCK=0, busy=0; no done pulse; readData=0.
- WIDTH=8, DIVIDER=1, mode 3 loopback of 8'h81 → masterChipSelectN low for 18 cycles; readData=8'h81.
